// File: rtl/gray_pkg.sv
// ============================================================================
// Module  : gray_pkg
// Brief   : Gray/binary conversion and popcount helpers shared with Bin2Gray.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package gray_pkg;

   localparam int c_ptr_max_w = 32;
   localparam int c_pop_w     = 6;

   typedef logic [c_ptr_max_w-1:0] ptr_word_t;
   typedef logic [c_pop_w-1:0]     pop_cnt_t;

   function automatic ptr_word_t bin2gray(input ptr_word_t b);
      return b ^ (b >> 1);
   endfunction

   // Callers zero-extend narrower pointers, so the unused upper bits decode to 0.
   function automatic ptr_word_t gray2bin(input ptr_word_t g);
      ptr_word_t b;
      b[c_ptr_max_w-1] = g[c_ptr_max_w-1];
      for (int i = c_ptr_max_w - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   function automatic pop_cnt_t popcount(input ptr_word_t v);
      pop_cnt_t n;
      n = '0;
      for (int i = 0; i < c_ptr_max_w; i++) begin
         n = n + pop_cnt_t'(v[i]);
      end
      return n;
   endfunction

endpackage

`default_nettype wire

// File: rtl/gray_sync.sv
// ============================================================================
// Module  : gray_sync
// Brief   : Multi-flop synchroniser for a Gray-coded word, async reset to 0.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_sync #(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   output logic [WIDTH-1:0] gray_s
);

   logic [WIDTH-1:0] r_stage [SYNC_STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stage[0] <= '0;
      end else begin
         r_stage[0] <= gray_in;
      end
   end

   for (genvar i = 1; i < SYNC_STAGES; i++) begin : g_stage
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_stage[i] <= '0;
         end else begin
            r_stage[i] <= r_stage[i-1];
         end
      end
   end

   assign gray_s = r_stage[SYNC_STAGES-1];

endmodule

`default_nettype wire

// File: rtl/gray_ptr_rx.sv
// ============================================================================
// Module  : gray_ptr_rx
// Brief   : Gray pointer receiver: sync, decode, step check and credit counter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module gray_ptr_rx
   import gray_pkg::*;
#(
   parameter int WIDTH       = 3,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = WIDTH + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     gray_in,
   output logic [WIDTH-1:0]     bin_out,
   output logic                 chg,
   output logic                 err,
   input  logic                 err_clr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] pend_cnt,
   output logic                 ovf
);

   logic [WIDTH-1:0]     w_gray_s;
   logic [WIDTH-1:0]     w_bin_s;
   logic [WIDTH-1:0]     w_bin_inc;
   pop_cnt_t             w_dist;
   logic                 w_changed;
   logic                 w_legal;
   logic                 w_pop;
   logic                 w_cnt_max;

   logic [WIDTH-1:0]     r_gray_q;
   logic [WIDTH-1:0]     r_bin;
   logic                 r_chg;
   logic                 r_err;
   logic                 r_ovf;
   logic [CNT_WIDTH-1:0] r_pend;

   gray_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst     (rst),
      .gray_in (gray_in),
      .gray_s  (w_gray_s)
   );

   // A legal step is a single-bit change whose decoded value is exactly one ahead.
   assign w_dist    = popcount(ptr_word_t'(w_gray_s ^ r_gray_q));
   assign w_bin_s   = WIDTH'(gray2bin(ptr_word_t'(w_gray_s)));
   assign w_bin_inc = r_bin + WIDTH'(1);
   assign w_changed = (w_dist != '0);
   assign w_legal   = (w_dist == pop_cnt_t'(1)) && (w_bin_s == w_bin_inc);

   assign out_valid = (r_pend != '0);
   assign w_pop     = out_valid & out_ready;
   assign w_cnt_max = &r_pend;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_gray_q <= '0;
         r_bin    <= '0;
         r_chg    <= 1'b0;
      end else begin
         r_chg <= w_changed;
         if (w_changed) begin
            r_gray_q <= w_gray_s;
            r_bin    <= w_bin_s;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         case ({w_legal, w_pop})
            2'b10:   r_pend <= w_cnt_max ? r_pend : r_pend + CNT_WIDTH'(1);
            2'b01:   r_pend <= r_pend - CNT_WIDTH'(1);
            default: r_pend <= r_pend;
         endcase
      end
   end

   // err_clr has priority over a same-cycle set on both sticky flags.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_err <= 1'b0;
         r_ovf <= 1'b0;
      end else if (err_clr) begin
         r_err <= 1'b0;
         r_ovf <= 1'b0;
      end else begin
         if (w_changed && !w_legal) begin
            r_err <= 1'b1;
         end
         if (w_legal && !w_pop && w_cnt_max) begin
            r_ovf <= 1'b1;
         end
      end
   end

   assign bin_out  = r_bin;
   assign chg      = r_chg;
   assign err      = r_err;
   assign ovf      = r_ovf;
   assign pend_cnt = r_pend;

endmodule

`default_nettype wire
